// File: rtl/multpath_tester.sv
// multpath_tester: sweeps every A/B pair into a multicycle adder and checks its sum
module multpath_tester #(
   parameter int INPUT_WIDTH = 4,
   parameter int SUM_WIDTH   = 5,
   parameter int HOLD_CYCLES = 4,
   parameter int ERR_WIDTH   = 9
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   start,
   output logic [INPUT_WIDTH-1:0] A,
   output logic [INPUT_WIDTH-1:0] B,
   input  logic [SUM_WIDTH-1:0]   sum,
   output logic                   busy,
   output logic                   done,
   output logic                   pass,
   output logic [ERR_WIDTH-1:0]   err_count,
   output logic                   first_err_valid,
   output logic [INPUT_WIDTH-1:0] first_err_A,
   output logic [INPUT_WIDTH-1:0] first_err_B
);
   typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DONE} state_t;
   localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
   localparam logic [INPUT_WIDTH-1:0] OP_MAX = '1;
   state_t state_q, state_d;
   logic [INPUT_WIDTH-1:0] a_q, a_d, b_q, b_d, fea_q, fea_d, feb_q, feb_d;
   logic [7:0] hold_q, hold_d;
   logic [ERR_WIDTH-1:0] err_q, err_d;
   logic fev_q, fev_d;
   logic launch, sample, last_pair, mismatch;
   logic [SUM_WIDTH-1:0] expect_sum;
   assign launch     = (state_q != S_DRIVE) && start;
   assign sample     = (state_q == S_DRIVE) && (hold_q == HOLD_LAST);
   assign last_pair  = (a_q == OP_MAX) && (b_q == OP_MAX);
   assign expect_sum = SUM_WIDTH'(a_q) + SUM_WIDTH'(b_q);
   assign mismatch   = sample && (sum != expect_sum);
   // state and datapath registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         hold_q  <= '0;
         err_q   <= '0;
         fev_q   <= 1'b0;
         fea_q   <= '0;
         feb_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hold_q  <= hold_d;
         err_q   <= err_d;
         fev_q   <= fev_d;
         fea_q   <= fea_d;
         feb_q   <= feb_d;
      end
   end
   // next state: start is only looked at outside DRIVE; the last compared pair ends the sweep
   always_comb begin
      state_d = launch ? S_DRIVE : (sample && last_pair) ? S_DONE : state_q;
   end
   // datapath next values: hold counting, pair advance, mismatch capture
   always_comb begin
      a_d    = a_q;
      b_d    = b_q;
      hold_d = hold_q;
      err_d  = err_q;
      fev_d  = fev_q;
      fea_d  = fea_q;
      feb_d  = feb_q;
      if (launch) begin
         a_d    = '0;
         b_d    = '0;
         hold_d = '0;
         err_d  = '0;
         fev_d  = 1'b0;
         fea_d  = '0;
         feb_d  = '0;
      end else if (state_q == S_DRIVE) begin
         hold_d = sample ? 8'd0 : hold_q + 8'd1;
         if (sample && !last_pair) begin
            b_d = b_q + 1'b1;
            if (b_q == OP_MAX) a_d = a_q + 1'b1;
         end
         if (mismatch) begin
            err_d = &err_q ? err_q : err_q + 1'b1;
            if (!fev_q) begin
               fev_d = 1'b1;
               fea_d = a_q;
               feb_d = b_q;
            end
         end
      end
   end
   // outputs decoded from state and result registers
   always_comb begin
      busy            = state_q == S_DRIVE;
      done            = state_q == S_DONE;
      pass            = (state_q == S_DONE) && (err_q == '0);
      A               = a_q;
      B               = b_q;
      err_count       = err_q;
      first_err_valid = fev_q;
      first_err_A     = fea_q;
      first_err_B     = feb_q;
   end
endmodule

// File: tb/tb_multpath_tester.sv
// tb_multpath_tester: directed checks of the operand sweeper against adder models
module tb_multpath_tester;
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, start6 = 1'b0;
   logic [1:0] mode = 2'd0;
   logic [3:0] A, B, fea, feb, A6, B6, fea6, feb6;
   logic [4:0] sum, sum6;
   logic busy, done, pass, fev, busy6, done6, pass6, fev6;
   logic [8:0] err, err6;
   logic [4:0] p [1:5];
   logic [4:0] q [1:5];
   int checks = 0, fails = 0;

   always #5 clk = ~clk;

   // adder models: a 5-deep register chain, tapped at 2 (ideal/stuck) or 5 (late)
   always @(posedge clk) begin
      p[1] <= 5'(A) + 5'(B);
      q[1] <= 5'(A6) + 5'(B6);
      for (int i = 2; i <= 5; i++) begin
         p[i] <= p[i-1];
         q[i] <= q[i-1];
      end
   end
   assign sum  = (mode == 2'd0) ? p[2] : (mode == 2'd1) ? {1'b0, p[2][3:0]} : p[5];
   assign sum6 = q[5];

   multpath_tester #(.INPUT_WIDTH(4), .SUM_WIDTH(5), .HOLD_CYCLES(4), .ERR_WIDTH(9)) dut (
      .clock(clk), .reset_n(rst_n), .start(start), .A(A), .B(B), .sum(sum),
      .busy(busy), .done(done), .pass(pass), .err_count(err),
      .first_err_valid(fev), .first_err_A(fea), .first_err_B(feb));

   multpath_tester #(.INPUT_WIDTH(4), .SUM_WIDTH(5), .HOLD_CYCLES(6), .ERR_WIDTH(9)) dut6 (
      .clock(clk), .reset_n(rst_n), .start(start6), .A(A6), .B(B6), .sum(sum6),
      .busy(busy6), .done(done6), .pass(pass6), .err_count(err6),
      .first_err_valid(fev6), .first_err_A(fea6), .first_err_B(feb6));

   function automatic logic [28:0] outs();
      return {A, B, busy, done, pass, err, fev, fea, feb};
   endfunction

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < 3000) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic test_reset();
      int bad = 0;
      repeat (3) @(negedge clk);
      checks++;
      if (outs() !== 29'd0) begin fails++; $display("FAIL reset_state: got %h expected 0", outs()); end
      rst_n = 1'b1;
      repeat (100) begin
         @(negedge clk);
         if (outs() !== 29'd0 || busy6 !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin fails++; $display("FAIL idle_no_start: got %0d bad cycles expected 0", bad); end
      pulse_start();
      checks++;
      if (busy !== 1'b1) begin fails++; $display("FAIL busy_after_start: got %b expected 1", busy); end
      repeat (20) @(negedge clk);
      checks++;
      if ({A, B} !== 8'h05) begin fails++; $display("FAIL pair_at_20: got %h expected 05", {A, B}); end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (outs() !== 29'd0) begin fails++; $display("FAIL async_reset: got %h expected 0", outs()); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_ideal();
      int n;
      mode = 2'd0;
      pulse_start();
      wait_done(n);
      checks++;
      if (n != 1024) begin fails++; $display("FAIL ideal_cycles: got %0d expected 1024", n); end
      checks++;
      if ({busy, done, pass, err, fev} !== {3'b011, 9'd0, 1'b0}) begin
         fails++; $display("FAIL ideal_result: got b%b d%b p%b e%0d v%b expected b0 d1 p1 e0 v0", busy, done, pass, err, fev);
      end
      checks++;
      if ({A, B} !== 8'hFF) begin fails++; $display("FAIL ideal_final_pair: got %h expected ff", {A, B}); end
   endtask

   task automatic test_stuck();
      int n;
      mode = 2'd1;
      pulse_start();
      wait_done(n);
      checks++;
      if (n != 1024) begin fails++; $display("FAIL stuck_cycles: got %0d expected 1024", n); end
      checks++;
      if (err !== 9'd120) begin fails++; $display("FAIL stuck_err: got %0d expected 120", err); end
      checks++;
      if ({pass, fev} !== 2'b01) begin fails++; $display("FAIL stuck_flags: got p%b v%b expected p0 v1", pass, fev); end
      checks++;
      if ({fea, feb} !== 8'h1F) begin fails++; $display("FAIL stuck_first: got %h expected 1f", {fea, feb}); end
   endtask

   task automatic test_back_to_back();
      int n = 0;
      pulse_start();
      while (!done && n < 3000) begin
         @(negedge clk);
         n++;
         if (n == 300) start = 1'b1;
         if (n == 303) start = 1'b0;
      end
      checks++;
      if (n != 1024) begin fails++; $display("FAIL ignore_start_cycles: got %0d expected 1024", n); end
      checks++;
      if (err !== 9'd120) begin fails++; $display("FAIL ignore_start_err: got %0d expected 120", err); end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if ({busy, done, err, fev} !== {2'b10, 9'd0, 1'b0}) begin
         fails++; $display("FAIL restart_clear: got b%b d%b e%0d v%b expected b1 d0 e0 v0", busy, done, err, fev);
      end
      checks++;
      if ({A, B} !== 8'h00) begin fails++; $display("FAIL restart_pair: got %h expected 00", {A, B}); end
      wait_done(n);
      checks++;
      if (n != 1024) begin fails++; $display("FAIL restart_cycles: got %0d expected 1024", n); end
      checks++;
      if ({err, pass, fev, fea, feb} !== {9'd120, 2'b01, 8'h1F}) begin
         fails++; $display("FAIL restart_result: got e%0d p%b v%b %h%h expected e120 p0 v1 1f", err, pass, fev, fea, feb);
      end
   endtask

   task automatic test_late();
      int n;
      @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      mode = 2'd2;
      repeat (10) @(negedge clk);
      pulse_start();
      wait_done(n);
      checks++;
      if (n != 1024) begin fails++; $display("FAIL late_cycles: got %0d expected 1024", n); end
      checks++;
      if ({err, pass} !== {9'd255, 1'b0}) begin fails++; $display("FAIL late_err: got e%0d p%b expected e255 p0", err, pass); end
      checks++;
      if ({fev, fea, feb} !== {1'b1, 8'h01}) begin fails++; $display("FAIL late_first: got v%b %h%h expected v1 01", fev, fea, feb); end
      @(negedge clk);
      start6 = 1'b1;
      @(negedge clk);
      start6 = 1'b0;
      checks++;
      if (busy6 !== 1'b1) begin fails++; $display("FAIL hold6_busy: got %b expected 1", busy6); end
      n = 0;
      while (!done6 && n < 4000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n != 1536) begin fails++; $display("FAIL hold6_cycles: got %0d expected 1536", n); end
      checks++;
      if ({err6, pass6, fev6} !== {9'd0, 2'b10}) begin fails++; $display("FAIL hold6_result: got e%0d p%b v%b expected e0 p1 v0", err6, pass6, fev6); end
   endtask

   task automatic test_reset_mid();
      int n;
      mode = 2'd0;
      pulse_start();
      repeat (500) @(negedge clk);
      checks++;
      if ({A, B} !== 8'h7D) begin fails++; $display("FAIL pair_at_500: got %h expected 7d", {A, B}); end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (outs() !== 29'd0) begin fails++; $display("FAIL mid_reset: got %h expected 0", outs()); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      checks++;
      if ({busy, done} !== 2'b00) begin fails++; $display("FAIL mid_reset_idle: got b%b d%b expected b0 d0", busy, done); end
      pulse_start();
      wait_done(n);
      checks++;
      if (n != 1024) begin fails++; $display("FAIL post_reset_cycles: got %0d expected 1024", n); end
      checks++;
      if ({pass, err, fev} !== {1'b1, 9'd0, 1'b0}) begin fails++; $display("FAIL post_reset_result: got p%b e%0d v%b expected p1 e0 v0", pass, err, fev); end
   endtask

   initial begin
      test_reset();
      test_ideal();
      test_stuck();
      test_back_to_back();
      test_late();
      test_reset_mid();
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end
endmodule
